// File: rtl/br_pkg.sv
// -----------------------------------------------------------------------------
// br_pkg
// Shared definitions for the branch resolution unit:
//   - br_op_e : branch/jump op encodings as presented by decode
//   - state_e : controller states (IDLE / EVAL / REDIR)
//   - DEFAULT_ADDR_W / DEFAULT_CNT_W : default datapath and counter widths
//   - is_branch_op / is_link_op : op classification helpers
// -----------------------------------------------------------------------------
package br_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_BEQ  = 4'd1,
        OP_BNE  = 4'd2,
        OP_BLEZ = 4'd3,
        OP_BGTZ = 4'd4,
        OP_BLTZ = 4'd5,
        OP_BGEZ = 4'd6,
        OP_J    = 4'd7,
        OP_JAL  = 4'd8,
        OP_JR   = 4'd9,
        OP_JALR = 4'd10
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    // Encodings 0 and 11..15 are all treated as "no branch".
    function automatic logic is_branch_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction

    function automatic logic is_link_op(input br_op_e op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/br_cond.sv
// -----------------------------------------------------------------------------
// br_cond
// Purely combinational branch condition and target evaluation.
// Ports:
//   op     in  captured branch op
//   d1, d2 in  forwarded rs / rt operand values
//   pc     in  PC of the branch instruction
//   imm    in  16-bit branch offset (word offset, sign-extended)
//   index  in  26-bit jump index
//   taken  out condition result (always 1 for jumps)
//   target out redirect target address
// -----------------------------------------------------------------------------
module br_cond
    import br_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  br_op_e              op,
    input  logic [ADDR_W-1:0]   d1,
    input  logic [ADDR_W-1:0]   d2,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [15:0]         imm,
    input  logic [25:0]         index,
    output logic                taken,
    output logic [ADDR_W-1:0]   target
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_off;
    logic              d1_neg;
    logic              d1_zero;

    assign pc_plus4 = pc + ADDR_W'(4);
    // Sign-extended word offset shifted into a byte offset.
    assign br_off   = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    assign d1_neg   = d1[ADDR_W-1];
    assign d1_zero  = (d1 == '0);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4 + br_off;
        case (op)
            OP_BEQ:  taken = (d1 == d2);
            OP_BNE:  taken = (d1 != d2);
            OP_BLEZ: taken = d1_neg | d1_zero;
            OP_BGTZ: taken = ~d1_neg & ~d1_zero;
            OP_BLTZ: taken = d1_neg;
            OP_BGEZ: taken = ~d1_neg;
            OP_J, OP_JAL: begin
                taken  = 1'b1;
                // Jump stays inside the 256 MB region of the delay-slot PC.
                target = {pc_plus4[ADDR_W-1:28], index, 2'b00};
            end
            OP_JR, OP_JALR: begin
                taken  = 1'b1;
                target = d1;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Decode-stage branch/jump resolution. Captures a branch, waits for the hazard
// unit to mark operands final, evaluates condition/target, then holds a PC
// redirect to fetch until accepted. Emits the JAL/JALR link write and keeps
// saturating resolved/taken statistics.
//
// Configuration macro: DELAY_SLOT_EN
//   defined   : delay slot always executes, link = pc+8, flush_if tied low
//   undefined : link = pc+4, flush_if pulses with redirect acceptance
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   br_valid/br_ready       branch handshake from decode (ready only in IDLE)
//   br_op/br_pc/br_imm/br_index  decoded branch fields
//   ops_ready, d1, d2       forwarded operands, final when ops_ready=1
//   redir_valid/redir_ready/redir_pc  held redirect to fetch
//   link_we, link_data      one-cycle return-address write
//   flush_if                kill wrong-path fetched instruction
//   stall                   freeze decode while busy
//   br_cnt, taken_cnt       saturating statistics
// -----------------------------------------------------------------------------
module branch_unit
    import br_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                br_valid,
    output logic                br_ready,
    input  logic [3:0]          br_op,
    input  logic [ADDR_W-1:0]   br_pc,
    input  logic [15:0]         br_imm,
    input  logic [25:0]         br_index,
    input  logic                ops_ready,
    input  logic [ADDR_W-1:0]   d1,
    input  logic [ADDR_W-1:0]   d2,
    output logic                redir_valid,
    input  logic                redir_ready,
    output logic [ADDR_W-1:0]   redir_pc,
    output logic                link_we,
    output logic [ADDR_W-1:0]   link_data,
    output logic                flush_if,
    output logic                stall,
    output logic [CNT_W-1:0]    br_cnt,
    output logic [CNT_W-1:0]    taken_cnt
);

`ifdef DELAY_SLOT_EN
    localparam logic [ADDR_W-1:0] LINK_OFS = ADDR_W'(8);
`else
    localparam logic [ADDR_W-1:0] LINK_OFS = ADDR_W'(4);
`endif

    state_e              state_q, state_d;
    br_op_e              op_q, op_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         imm_q, imm_d;
    logic [25:0]         index_q, index_d;
    logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;
    logic                link_q, link_d;
    logic [ADDR_W-1:0]   link_data_q, link_data_d;
    logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;

    logic                cond_taken;
    logic [ADDR_W-1:0]   cond_target;
    logic                redir_acc;

    br_cond #(.ADDR_W(ADDR_W)) u_br_cond (
        .op     (op_q),
        .d1     (d1),
        .d2     (d2),
        .pc     (pc_q),
        .imm    (imm_q),
        .index  (index_q),
        .taken  (cond_taken),
        .target (cond_target)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        index_d     = index_q;
        redir_pc_d  = redir_pc_q;
        link_d      = link_q;
        link_data_d = link_data_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (br_valid && is_branch_op(br_op)) begin
                    op_d    = br_op_e'(br_op);
                    pc_d    = br_pc;
                    imm_d   = br_imm;
                    index_d = br_index;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (ops_ready) begin
                    if (!(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
                    if (cond_taken) begin
                        if (!(&taken_cnt_q)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
                        redir_pc_d = cond_target;
                        link_d     = is_link_op(op_q);
                        if (is_link_op(op_q)) link_data_d = pc_q + LINK_OFS;
                        state_d    = ST_REDIR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REDIR: begin
                if (redir_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            pc_q        <= '0;
            imm_q       <= '0;
            index_q     <= '0;
            redir_pc_q  <= '0;
            link_q      <= 1'b0;
            link_data_q <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            index_q     <= index_d;
            redir_pc_q  <= redir_pc_d;
            link_q      <= link_d;
            link_data_q <= link_data_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Qualifying with reset_n drops a redirect (and its link/flush strobes)
    // that would otherwise be handshaken in the same cycle reset is asserted.
    assign redir_valid = reset_n && (state_q == ST_REDIR);
    assign redir_acc   = redir_valid && redir_ready;

    assign br_ready  = (state_q == ST_IDLE);
    assign stall     = (state_q != ST_IDLE);
    assign redir_pc  = redir_pc_q;
    assign link_we   = redir_acc && link_q;
    assign link_data = link_data_q;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

`ifdef DELAY_SLOT_EN
    assign flush_if = 1'b0;
`else
    assign flush_if = redir_acc;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
// Self-checking bench for branch_unit. Expected redirects are pushed to a
// scoreboard queue when a branch is issued and popped by a monitor on the
// falling edge whenever fetch accepts a redirect.
// -----------------------------------------------------------------------------
module tb_branch_unit;

`ifdef DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFS  = 32'd8;
    localparam logic        FLUSH_EXP = 1'b0;
`else
    localparam logic [31:0] LINK_OFS  = 32'd4;
    localparam logic        FLUSH_EXP = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_op;
    logic [31:0] br_pc;
    logic [15:0] br_imm;
    logic [25:0] br_index;
    logic        ops_ready;
    logic [31:0] d1, d2;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        link_we;
    logic [31:0] link_data;
    logic        flush_if;
    logic        stall;
    logic [15:0] br_cnt, taken_cnt;

    typedef struct {
        logic [31:0] pc;
        logic        link;
        logic [31:0] ldata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_br = 0;
    int   m_taken = 0;

    always #5 clk = ~clk;

    branch_unit #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_op       (br_op),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .br_index    (br_index),
        .ops_ready   (ops_ready),
        .d1          (d1),
        .d2          (d2),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .link_we     (link_we),
        .link_data   (link_data),
        .flush_if    (flush_if),
        .stall       (stall),
        .br_cnt      (br_cnt),
        .taken_cnt   (taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Redirect-acceptance monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (redir_valid && redir_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_redir", 32'(redir_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc_redir_pc", redir_pc, e.pc);
                check("acc_link_we", 32'(link_we), 32'(e.link));
                if (e.link) check("acc_link_data", link_data, e.ldata);
                check("acc_flush_if", 32'(flush_if), 32'(FLUSH_EXP));
            end
        end else begin
            check("stray_link_we", 32'(link_we), 32'd0);
            check("stray_flush_if", 32'(flush_if), 32'd0);
        end
    end

    function automatic logic model_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a == b;
            4'd2:    return a != b;
            4'd3:    return $signed(a) <= 0;
            4'd4:    return $signed(a) > 0;
            4'd5:    return $signed(a) < 0;
            4'd6:    return $signed(a) >= 0;
            4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] a, input logic [31:0] b,
                         input int ops_wait, input int rdy_wait,
                         input logic exp_taken, input logic [31:0] exp_tgt);
        exp_t e;
        int   guard;
        guard = 0;
        while (!br_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 32'(br_ready), 32'd1);
        br_valid = 1'b1; br_op = op; br_pc = pc; br_imm = imm; br_index = idx;
        if (exp_taken) begin
            e.pc    = exp_tgt;
            e.link  = (op == 4'd8) || (op == 4'd10);
            e.ldata = pc + LINK_OFS;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        br_valid = 1'b0; br_op = 4'd0;
        check("stall_eval", 32'(stall), 32'd1);
        repeat (ops_wait) begin
            @(posedge clk); #1;
            check("stall_wait_ops", 32'(stall), 32'd1);
            check("no_redir_wait_ops", 32'(redir_valid), 32'd0);
        end
        d1 = a; d2 = b; ops_ready = 1'b1;
        @(posedge clk); #1;
        ops_ready = 1'b0; d1 = $urandom; d2 = $urandom;
        m_br++;
        if (!exp_taken) begin
            check("nt_br_ready", 32'(br_ready), 32'd1);
            check("nt_redir_valid", 32'(redir_valid), 32'd0);
        end else begin
            m_taken++;
            check("redir_valid", 32'(redir_valid), 32'd1);
            check("redir_pc", redir_pc, exp_tgt);
            repeat (rdy_wait) begin
                @(posedge clk); #1;
                check("stall_wait_rdy", 32'(stall), 32'd1);
                check("redir_pc_stable", redir_pc, exp_tgt);
            end
            redir_ready = 1'b1;
            @(posedge clk); #1;
            redir_ready = 1'b0;
            check("idle_after_acc", 32'(br_ready), 32'd1);
            check("redir_dropped", 32'(redir_valid), 32'd0);
        end
        check("br_cnt", 32'(br_cnt), 32'(m_br));
        check("taken_cnt", 32'(taken_cnt), 32'(m_taken));
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_pc, r_a, r_b, r_tgt;
        logic [15:0] r_imm;

        reset_n = 1'b0; br_valid = 1'b0; br_op = 4'd0; br_pc = '0; br_imm = '0;
        br_index = '0; ops_ready = 1'b0; d1 = '0; d2 = '0; redir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_br_ready", 32'(br_ready), 32'd1);
        check("rst_redir_valid", 32'(redir_valid), 32'd0);
        check("rst_redir_pc", redir_pc, 32'd0);
        check("rst_link_data", link_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_br_cnt", 32'(br_cnt), 32'd0);
        check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // NONE encodings (0 and 11..15) are ignored.
        br_valid = 1'b1; br_op = 4'd0;
        @(posedge clk); #1;
        br_op = 4'd12;
        @(posedge clk); #1;
        br_valid = 1'b0;
        check("none_stall", 32'(stall), 32'd0);
        check("none_br_cnt", 32'(br_cnt), 32'd0);

        // Directed cases with hand-computed targets.
        issue(4'd1, 32'h0000_3000, 16'h0004, 26'd0, 32'd5, 32'd5, 0, 0, 1'b1, 32'h0000_3014);
        issue(4'd2, 32'h0000_3000, 16'h0004, 26'd0, 32'd7, 32'd7, 0, 0, 1'b0, 32'd0);
        issue(4'd4, 32'h0000_4000, 16'hFFFF, 26'd0, 32'd0, 32'd0, 0, 0, 1'b0, 32'd0);
        issue(4'd4, 32'h0000_4000, 16'hFFFF, 26'd0, 32'd1, 32'd0, 0, 0, 1'b1, 32'h0000_4000);
        issue(4'd3, 32'hFFFF_FFF8, 16'h0001, 26'd0, 32'h8000_0000, 32'd0, 0, 1, 1'b1, 32'h0000_0000);
        issue(4'd5, 32'h0000_5000, 16'h0010, 26'd0, 32'd0, 32'd0, 1, 0, 1'b0, 32'd0);
        issue(4'd8, 32'h0000_3008, 16'h0000, 26'h0000C10, 32'd0, 32'd0, 0, 0, 1'b1, 32'h0000_3040);
        issue(4'd9, 32'h0000_6000, 16'h0000, 26'd0, 32'h1234_5679, 32'd0, 3, 2, 1'b1, 32'h1234_5679);
        issue(4'd10, 32'h0000_7000, 16'h0000, 26'd0, 32'h0000_0100, 32'd0, 0, 0, 1'b1, 32'h0000_0100);
        issue(4'd7, 32'hA000_0000, 16'h0000, 26'h3FFFFFF, 32'd0, 32'd0, 0, 0, 1'b1, 32'hAFFF_FFFC);

        // Randomized conditional branches against the bench model.
        for (int i = 0; i < 16; i++) begin
            r_op  = 4'($urandom_range(1, 6));
            r_pc  = $urandom & 32'hFFFF_FFFC;
            r_imm = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r_a = 32'd0;
                1: r_a = 32'h8000_0000;
                2: r_a = 32'd1;
                default: r_a = $urandom;
            endcase
            r_b   = ($urandom_range(0, 1) == 0) ? r_a : $urandom;
            r_tgt = r_pc + 32'd4 + {{14{r_imm[15]}}, r_imm, 2'b00};
            issue(r_op, r_pc, r_imm, 26'd0, r_a, r_b, $urandom_range(0, 2),
                  $urandom_range(0, 2), model_taken(r_op, r_a, r_b), r_tgt);
        end

        // Reset while holding a JALR redirect; fetch is ready during reset.
        br_valid = 1'b1; br_op = 4'd10; br_pc = 32'h0000_8000;
        @(posedge clk); #1;
        br_valid = 1'b0; br_op = 4'd0;
        d1 = 32'h0000_9000; ops_ready = 1'b1;
        @(posedge clk); #1;
        ops_ready = 1'b0;
        check("pre_rst_redir_valid", 32'(redir_valid), 32'd1);
        reset_n = 1'b0; redir_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1; redir_ready = 1'b0;
        m_br = 0; m_taken = 0;
        check("post_rst_redir_valid", 32'(redir_valid), 32'd0);
        check("post_rst_br_ready", 32'(br_ready), 32'd1);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_br_cnt", 32'(br_cnt), 32'(m_br));
        check("post_rst_taken_cnt", 32'(taken_cnt), 32'(m_taken));
        check("post_rst_redir_pc", redir_pc, 32'd0);
        check("post_rst_link_data", link_data, 32'd0);

        // Unit must be fully usable after the mid-redirect reset.
        issue(4'd6, 32'h0000_1000, 16'h0002, 26'd0, 32'd3, 32'd0, 0, 0, 1'b1, 32'h0000_100C);

        @(posedge clk); #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
